ble_telemetry_tx: RTL

Serial transmitter for the BLE link: packs a snapshot of MPU roll/pitch/yaw into a fixed 8-byte framed packet and shifts it out 8N1 on the UART line that drives `BLE_UART_RX` of the BLE module. The bluetooth wrapper receives commands; this block sends telemetry back the other way. It sits beside `MPU_Controller` in `Top`, with `send` strobed by a periodic tick or a host request.

---
 rtl/ble_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 83 ++++++++
 rtl/ble_telemetry_tx.sv | 93 +++++++++
 3 files changed

// File: rtl/ble_pkg.sv
// Shared constants, FSM state types and packet helpers for the BLE telemetry transmitter.
package ble_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PKT_LEN   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XMIT,
    DONE
  } pkt_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  function automatic logic [15:0] sext16(input logic signed [9:0] v);
    return {{6{v[9]}}, v};
  endfunction

  // XOR of the six payload bytes; SYNC never takes part.
  function automatic logic [7:0] xor_bytes(input logic [47:0] payload);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 6; i++) acc ^= payload[i*8 +: 8];
    return acc;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready also rises in the last stop-bit cycle so bytes chain without a gap.
module uart_tx_byte
  import ble_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int               CNT_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  byte_state_t      state, state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             baud_end;
  logic             tx_next;

  assign baud_end = (baud_cnt == CNT_MAX);
  assign ready    = (state == B_IDLE) || ((state == B_STOP) && baud_end);

  // NOTE: every signal written here gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    unique case (state)
      B_IDLE:  if (start) begin
                 state_next = B_START;
                 tx_next    = 1'b0;
               end
      B_START: if (baud_end) begin
                 state_next = B_DATA;
                 tx_next    = shreg[0];
               end
      B_DATA:  if (baud_end) begin
                 if (bit_cnt == 3'd7) begin
                   state_next = B_STOP;
                   tx_next    = 1'b1;
                 end else begin
                   tx_next    = shreg[1];
                 end
               end
      B_STOP:  if (baud_end) begin
                 state_next = start ? B_START : B_IDLE;
                 tx_next    = ~start;
               end
      default: begin
                 state_next = B_IDLE;
                 tx_next    = 1'b1;
               end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= B_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      tx       <= 1'b1;
    end else begin
      state <= state_next;
      tx    <= tx_next;

      if ((state == B_IDLE) || baud_end) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;

      if (ready && start)                   shreg <= data;
      else if ((state == B_DATA) && baud_end) shreg <= shreg >> 1;

      if (state == B_START)                   bit_cnt <= 3'd0;
      else if ((state == B_DATA) && baud_end) bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/ble_telemetry_tx.sv
// Snapshots roll/pitch/yaw on send and streams an 8-byte framed packet out over 8N1 UART.
module ble_telemetry_tx
  import ble_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send,
  input  logic signed [9:0] roll,
  input  logic signed [9:0] pitch,
  input  logic signed [9:0] yaw,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  localparam int         BAUD_DIV = CLK_HZ / BAUD;
  localparam logic [3:0] IDX_END  = 4'(PKT_LEN);

  pkt_state_t        state, state_next;
  logic signed [9:0] roll_q, pitch_q, yaw_q;
  logic [63:0]       buffer;
  logic [47:0]       payload;
  logic [3:0]        byte_idx;
  logic              eng_start;
  logic              eng_ready;

  assign payload = {sext16(roll_q), sext16(pitch_q), sext16(yaw_q)};

  always_comb begin
    state_next = state;
    eng_start  = 1'b0;
    unique case (state)
      IDLE: if (send) state_next = LOAD;
      LOAD: state_next = XMIT;
      XMIT: begin
        if (byte_idx == IDX_END) begin
          // All bytes issued; the engine reports ready again in byte 7's last stop-bit cycle.
          if (eng_ready) state_next = DONE;
        end else begin
          eng_start = eng_ready;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      roll_q   <= '0;
      pitch_q  <= '0;
      yaw_q    <= '0;
      buffer   <= '0;
      byte_idx <= 4'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next == XMIT);
      done  <= (state_next == DONE);

      if ((state == IDLE) && send) begin
        roll_q  <= roll;
        pitch_q <= pitch;
        yaw_q   <= yaw;
      end

      if (state == LOAD) begin
        buffer   <= {SYNC_BYTE, payload, xor_bytes(payload)};
        byte_idx <= 4'd0;
      end else if (eng_start) begin
        buffer   <= buffer << 8;
        byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .clock(clock),
    .reset(reset),
    .start(eng_start),
    .data (buffer[63:56]),
    .tx   (tx),
    .ready(eng_ready)
  );

endmodule
